// File: rtl/mdio_phy_responder_if.sv
// Management-side signal bundle for the MDIO PHY responder. The MDIO pin
// itself is tri-state and is kept as a plain inout on the responder.
interface mdio_phy_responder_if;
  logic        mdc;
  logic [15:0] status_in;
  logic        wr_valid;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;
  logic        rd_done;
  logic        frame_err;
  logic        busy;

  modport master (
    output mdc, status_in,
    input  wr_valid, wr_addr, wr_data, rd_done, frame_err, busy
  );

  modport slave (
    input  mdc, status_in,
    output wr_valid, wr_addr, wr_data, rd_done, frame_err, busy
  );
endinterface

// File: rtl/mdio_phy_responder.sv
// mdio_phy_responder: clause-22 MDIO station-management slave backed by a
// 32x16 register file. MDC/MDIO are oversampled in sys_clk; master-driven
// bits are taken on MDC rise, our own drive changes on MDC fall.
module mdio_phy_responder #(
  parameter logic [4:0] PHY_ADDR     = 5'd0,
  parameter logic [4:0] STATUS_REG   = 5'd1,
  parameter int         PREAMBLE_LEN = 32
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  inout  wire                 mdio,
  mdio_phy_responder_if.slave bus
);
  typedef enum logic [3:0] {
    S_IDLE, S_ST2, S_OP, S_PHYAD, S_REGAD, S_SKIP,
    S_WTA, S_WDATA, S_RTA, S_RTA2, S_RDATA
  } state_t;

  localparam logic [5:0] PRE_MAX = 6'(PREAMBLE_LEN);

  logic [2:0]  mdc_pipe;
  logic [1:0]  mdio_pipe;
  logic        mdc_rise, mdc_fall, mdio_bit, any_edge, abort;
  state_t      state;
  logic [5:0]  pre_cnt;
  logic [4:0]  cnt;
  logic        op_hi, op_wr;
  logic [4:0]  phyad, regad, regad_nxt;
  logic [15:0] wdata, wdata_nxt, rd_word;
  logic        mdio_oe, mdio_o;
  logic [9:0]  idle_cnt;
  logic [15:0] rf [32];

  assign mdc_rise  = mdc_pipe[1] & ~mdc_pipe[2];
  assign mdc_fall  = ~mdc_pipe[1] & mdc_pipe[2];
  assign mdio_bit  = mdio_pipe[1];
  assign any_edge  = mdc_rise | mdc_fall;
  assign abort     = (state != S_IDLE) && !any_edge && (idle_cnt == 10'd1023);
  assign regad_nxt = {regad[3:0], mdio_bit};
  assign wdata_nxt = {wdata[14:0], mdio_bit};

  // Reset gates the pad directly so the bus is freed without waiting for a clock.
  assign mdio = (mdio_oe && sys_rst_n) ? mdio_o : 1'bz;

  // Two-flop synchronisers; the third MDC flop gives edge detection.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mdc_pipe  <= '0;
      mdio_pipe <= '0;
    end else begin
      mdc_pipe  <= {mdc_pipe[1:0], bus.mdc};
      mdio_pipe <= {mdio_pipe[0], mdio};
    end
  end

  // Watchdog: sys_clk cycles since the last MDC edge while a frame is open.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)                                  idle_cnt <= '0;
    else if (state == S_IDLE || any_edge || abort)   idle_cnt <= '0;
    else                                             idle_cnt <= idle_cnt + 10'd1;
  end

  // Frame decoder, register file and MDIO drive.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state         <= S_IDLE;
      pre_cnt       <= '0;
      cnt           <= '0;
      op_hi         <= 1'b0;
      op_wr         <= 1'b0;
      phyad         <= '0;
      regad         <= '0;
      wdata         <= '0;
      rd_word       <= '0;
      mdio_oe       <= 1'b0;
      mdio_o        <= 1'b0;
      bus.wr_valid  <= 1'b0;
      bus.wr_addr   <= '0;
      bus.wr_data   <= '0;
      bus.rd_done   <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.busy      <= 1'b0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      bus.wr_valid  <= 1'b0;
      bus.rd_done   <= 1'b0;
      bus.frame_err <= 1'b0;
      if (abort) begin
        state    <= S_IDLE;
        mdio_oe  <= 1'b0;
        pre_cnt  <= '0;
        bus.busy <= 1'b0;
      end else if (mdc_rise) begin
        case (state)
          S_IDLE: begin
            if (mdio_bit) begin
              if (pre_cnt != PRE_MAX) pre_cnt <= pre_cnt + 6'd1;
            end else begin
              if (pre_cnt == PRE_MAX) state <= S_ST2;
              pre_cnt <= '0;
            end
          end
          S_ST2: begin
            if (mdio_bit) begin
              state    <= S_OP;
              cnt      <= '0;
              bus.busy <= 1'b1;
            end else begin
              state         <= S_IDLE;
              bus.frame_err <= 1'b1;
            end
          end
          S_OP: begin
            if (cnt == 5'd0) begin
              op_hi <= mdio_bit;
              cnt   <= 5'd1;
            end else begin
              cnt <= '0;
              if (op_hi != mdio_bit) begin
                op_wr <= mdio_bit;
                state <= S_PHYAD;
              end else begin
                state         <= S_IDLE;
                bus.busy      <= 1'b0;
                bus.frame_err <= 1'b1;
              end
            end
          end
          S_PHYAD: begin
            phyad <= {phyad[3:0], mdio_bit};
            cnt   <= (cnt == 5'd4) ? 5'd0 : cnt + 5'd1;
            if (cnt == 5'd4) state <= S_REGAD;
          end
          S_REGAD: begin
            regad <= regad_nxt;
            cnt   <= (cnt == 5'd4) ? 5'd0 : cnt + 5'd1;
            if (cnt == 5'd4) begin
              if (phyad != PHY_ADDR) begin
                state <= S_SKIP;
              end else begin
                rd_word <= (regad_nxt == STATUS_REG) ? bus.status_in : rf[regad_nxt];
                state   <= op_wr ? S_WTA : S_RTA;
              end
            end
          end
          // Other PHY's frame: ride out TA + DATA without touching the bus.
          S_SKIP: begin
            cnt <= cnt + 5'd1;
            if (cnt == 5'd17) begin
              state    <= S_IDLE;
              bus.busy <= 1'b0;
            end
          end
          S_WTA: begin
            cnt <= (cnt == 5'd1) ? 5'd0 : cnt + 5'd1;
            if (cnt == 5'd1) state <= S_WDATA;
          end
          S_WDATA: begin
            wdata <= wdata_nxt;
            cnt   <= cnt + 5'd1;
            if (cnt == 5'd15) begin
              if (regad != STATUS_REG) rf[regad] <= wdata_nxt;
              bus.wr_valid <= 1'b1;
              bus.wr_addr  <= regad;
              bus.wr_data  <= wdata_nxt;
              bus.busy     <= 1'b0;
              state        <= S_IDLE;
            end
          end
          S_RTA:   state <= S_RTA2;
          default: ;
        endcase
      end else if (mdc_fall) begin
        case (state)
          // Second TA bit: take the bus and drive 0.
          S_RTA2: begin
            mdio_oe <= 1'b1;
            mdio_o  <= 1'b0;
            cnt     <= '0;
            state   <= S_RDATA;
          end
          S_RDATA: begin
            if (cnt == 5'd16) begin
              mdio_oe     <= 1'b0;
              bus.rd_done <= 1'b1;
              bus.busy    <= 1'b0;
              state       <= S_IDLE;
            end else begin
              mdio_o  <= rd_word[15];
              rd_word <= {rd_word[14:0], 1'b0};
              cnt     <= cnt + 5'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mdio_phy_responder.sv
// Bench for mdio_phy_responder: a bit-banged MDIO master drives frames, a
// register-file model predicts DUT events into a queue, and a monitor pops
// and compares on every wr_valid / rd_done / frame_err pulse.
module tb_mdio_phy_responder;
  localparam int HALF = 80;  // MDC half period in ns (sys_clk is 10 ns)

  logic sys_clk = 1'b0;
  logic sys_rst_n;
  logic m_oe, m_out;
  wire  mdio;

  assign mdio = m_oe ? m_out : 1'bz;

  mdio_phy_responder_if bus_if();

  mdio_phy_responder dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .mdio      (mdio),
    .bus       (bus_if)
  );

  always #5 sys_clk = ~sys_clk;

  typedef enum logic [1:0] {EV_WR, EV_RD, EV_ERR} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [4:0]  addr;
    logic [16:0] data;  // reads: {TA bit 2, D15..D0}
  } ev_t;

  ev_t         exp_q[$];
  ev_t         mon_e;
  int          checks = 0;
  int          failures = 0;
  logic [15:0] model_rf [32];
  logic [16:0] rd_cap;
  bit          busy_seen, oe_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, req, $time);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s pulse with no expected event @%0t", name, $time);
  endtask

  // Monitor: every DUT event must match the head of the expectation queue.
  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (bus_if.busy) busy_seen = 1'b1;
      if (dut.mdio_oe) oe_seen = 1'b1;
      if (bus_if.wr_valid) begin
        if (exp_q.size() == 0) unexpected("wr_valid");
        else begin
          mon_e = exp_q.pop_front();
          chk("wr_kind", 32'(mon_e.kind), 32'(EV_WR));
          chk("wr_addr", 32'(bus_if.wr_addr), 32'(mon_e.addr));
          chk("wr_data", 32'(bus_if.wr_data), 32'(mon_e.data[15:0]));
        end
      end
      if (bus_if.rd_done) begin
        if (exp_q.size() == 0) unexpected("rd_done");
        else begin
          mon_e = exp_q.pop_front();
          chk("rd_kind", 32'(mon_e.kind), 32'(EV_RD));
          chk("rd_data", 32'(rd_cap), 32'(mon_e.data));
        end
      end
      if (bus_if.frame_err) begin
        if (exp_q.size() == 0) unexpected("frame_err");
        else begin
          mon_e = exp_q.pop_front();
          chk("err_kind", 32'(mon_e.kind), 32'(EV_ERR));
        end
      end
    end
  end

  task automatic send_bit(input logic b);
    m_oe  = 1'b1;
    m_out = b;
    #HALF bus_if.mdc = 1'b1;
    #HALF bus_if.mdc = 1'b0;
  endtask

  task automatic recv_bit(output logic b);
    m_oe = 1'b0;
    #(HALF - 2) b = mdio;
    #2 bus_if.mdc = 1'b1;
    #HALF bus_if.mdc = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  // One complete frame from the master; the model decides what the PHY must do.
  task automatic frame(input int pre, input logic [1:0] op, input logic [4:0] phy,
                       input logic [4:0] ra, input logic [15:0] wd, input bit quiet);
    logic        b, ta1_oe;
    logic [16:0] cap;
    bit          valid_op;
    valid_op = (op == 2'b01) || (op == 2'b10);
    if (pre >= 32) begin
      if (!valid_op) exp_q.push_back('{kind: EV_ERR, addr: 5'd0, data: 17'd0});
      else if (phy == 5'd0) begin
        if (op == 2'b01) begin
          exp_q.push_back('{kind: EV_WR, addr: ra, data: {1'b0, wd}});
          if (ra != 5'd1) model_rf[ra] = wd;
        end else begin
          exp_q.push_back('{kind: EV_RD, addr: ra,
                            data: {1'b0, (ra == 5'd1) ? bus_if.status_in : model_rf[ra]}});
        end
      end
    end
    busy_seen = 1'b0;
    oe_seen   = 1'b0;
    send_bits('1, pre);
    send_bits(32'b01, 2);
    send_bits(32'(op), 2);
    if (valid_op || pre < 32) begin
      send_bits(32'(phy), 5);
      send_bits(32'(ra), 5);
      if (op == 2'b10) begin
        recv_bit(b);
        ta1_oe = dut.mdio_oe;
        for (int i = 16; i >= 0; i--) begin
          recv_bit(b);
          cap[i] = b;
        end
        rd_cap = cap;
        if (pre >= 32 && phy == 5'd0) chk("ta1_z", 32'(ta1_oe), 32'd0);
        #HALF;  // let the PHY release the bus before we drive again
      end else begin
        send_bits(32'b10, 2);
        send_bits(32'(wd), 16);
      end
    end
    if (quiet) chk("skip_quiet", 32'(oe_seen), 32'd0);
  endtask

  initial begin
    int          r, pre;
    logic [1:0]  op;
    logic [4:0]  phy, ra;
    logic [15:0] wd;
    logic        b;

    bus_if.mdc       = 1'b0;
    bus_if.status_in = 16'h0;
    m_oe             = 1'b1;
    m_out            = 1'b1;
    for (int i = 0; i < 32; i++) model_rf[i] = 16'h0;
    sys_rst_n = 1'b1;
    #1 sys_rst_n = 1'b0;
    #40;
    chk("rst_busy",      32'(bus_if.busy),      32'd0);
    chk("rst_wr_valid",  32'(bus_if.wr_valid),  32'd0);
    chk("rst_rd_done",   32'(bus_if.rd_done),   32'd0);
    chk("rst_frame_err", 32'(bus_if.frame_err), 32'd0);
    chk("rst_mdio_oe",   32'(dut.mdio_oe),      32'd0);
    #2 sys_rst_n = 1'b1;
    #100;

    // Write then read back register 0.
    frame(32, 2'b01, 5'd0, 5'd0, 16'h0100, 1'b0);
    frame(32, 2'b10, 5'd0, 5'd0, 16'h0, 1'b0);

    // Status register: live read, write is acknowledged but not stored.
    bus_if.status_in = 16'h796D;
    frame(32, 2'b10, 5'd0, 5'd1, 16'h0, 1'b0);
    frame(32, 2'b01, 5'd0, 5'd1, 16'hFFFF, 1'b0);
    frame(32, 2'b10, 5'd0, 5'd1, 16'h0, 1'b0);

    // Foreign PHY address is ignored; the next frame to us decodes normally.
    frame(32, 2'b01, 5'd3, 5'd5, 16'hBEEF, 1'b1);
    frame(32, 2'b10, 5'd0, 5'd5, 16'h0, 1'b0);
    frame(32, 2'b01, 5'd0, 5'd5, 16'h5A5A, 1'b0);

    // Short preamble and illegal opcode.
    frame(31, 2'b01, 5'd0, 5'd2, 16'h1234, 1'b0);
    chk("pre31_busy", 32'(busy_seen), 32'd0);
    frame(32, 2'b11, 5'd0, 5'd0, 16'h0, 1'b0);
    chk("op11_busy", 32'(bus_if.busy), 32'd0);

    // Randomised traffic against the model.
    for (int n = 0; n < 28; n++) begin
      r                = int'($urandom_range(0, 9));
      bus_if.status_in = 16'($urandom);
      op  = (r < 4) ? 2'b01 : (r < 8) ? 2'b10 : (r == 8) ? 2'b00 : 2'b11;
      phy = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      ra  = 5'($urandom_range(0, 7));
      pre = 32 + int'($urandom_range(0, 4));
      wd  = 16'($urandom);
      frame(pre, op, phy, ra, wd, (phy != 5'd0) && (op == 2'b01 || op == 2'b10));
    end

    // MDC stalls mid-write: frame abandoned, register untouched.
    frame(32, 2'b01, 5'd0, 5'd2, 16'hA5A5, 1'b0);
    send_bits('1, 32);
    send_bits(32'b01, 2);
    send_bits(32'b01, 2);
    send_bits(32'd0, 5);
    send_bits(32'd2, 5);
    send_bits(32'b10, 2);
    send_bits(32'h3C, 8);
    chk("stall_busy_before", 32'(bus_if.busy), 32'd1);
    #(1100 * 10);
    chk("stall_busy_after", 32'(bus_if.busy), 32'd0);
    frame(32, 2'b10, 5'd0, 5'd2, 16'h0, 1'b0);

    // Reset while driving read data bit D7.
    frame(32, 2'b01, 5'd0, 5'd9, 16'hC3C3, 1'b0);
    send_bits('1, 32);
    send_bits(32'b01, 2);
    send_bits(32'b10, 2);
    send_bits(32'd0, 5);
    send_bits(32'd9, 5);
    for (int i = 0; i < 10; i++) recv_bit(b);  // TA1, TA2, D15..D8
    #(HALF / 2);
    chk("pre_rst_oe", 32'(dut.mdio_oe), 32'd1);
    sys_rst_n = 1'b0;
    #1;
    chk("midrst_oe",        32'(dut.mdio_oe),      32'd0);
    chk("midrst_busy",      32'(bus_if.busy),      32'd0);
    chk("midrst_wr_addr",   32'(bus_if.wr_addr),   32'd0);
    chk("midrst_wr_data",   32'(bus_if.wr_data),   32'd0);
    chk("midrst_rd_done",   32'(bus_if.rd_done),   32'd0);
    chk("midrst_frame_err", 32'(bus_if.frame_err), 32'd0);
    for (int i = 0; i < 32; i++) model_rf[i] = 16'h0;
    #50 sys_rst_n = 1'b1;
    #(2 * HALF);
    frame(32, 2'b10, 5'd0, 5'd9, 16'h0, 1'b0);
    frame(32, 2'b01, 5'd0, 5'd9, 16'h1E1E, 1'b0);
    frame(32, 2'b10, 5'd0, 5'd9, 16'h0, 1'b0);

    #2000;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mdio_phy_responder.md
Name: mdio_phy_responder

Overview:
- PHY-side (station management slave) end of the IEEE 802.3 clause-22 MDIO link, driven by the team's MDIO master.
- Oversamples MDC/MDIO in the sys_clk domain and decodes preamble, ST, OP, PHYAD, REGAD, TA and DATA fields.
- Holds a 32 x 16 register file: answers read frames by driving MDIO and commits write frames.
- Used as an on-chip loopback target for master bring-up, and as a lightweight emulated PHY.

Parameters:
- PHY_ADDR, 5'd0, PHYAD this block responds to.
- STATUS_REG, 5'd1, register address whose reads return status_in instead of the register file.
- PREAMBLE_LEN, 32, consecutive 1 bits required before ST; range 1..32.

Ports:
- sys_clk  in  1  system clock; must be at least 8x the MDC frequency.
- sys_rst_n  in  1  asynchronous active-low reset.
- mdc  in  1  management clock from master, asynchronous to sys_clk.
- mdio  inout  1  management data; driven only while the block owns the bus, otherwise 1'bz.
- status_in  in  16  live value returned for reads of STATUS_REG.
- wr_valid  out  1  one-sys_clk pulse when a write frame commits.
- wr_addr  out  5  REGAD of the last committed write.
- wr_data  out  16  DATA of the last committed write.
- rd_done  out  1  one-sys_clk pulse after the last read data bit is driven.
- frame_err  out  1  one-sys_clk pulse on a bad ST or OP.
- busy  out  1  high from a valid ST until frame end or abort.

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0; mdio released (Z).
  - Register file all 0; FSM in IDLE; preamble counter 0.
- Synchronisation:
  - mdc and mdio each pass through 2 flops; a 3rd mdc flop provides edge detect.
  - mdc_rise/mdc_fall are single-cycle strobes, 3 sys_clk after the pin edge.
- Sampling and driving:
  - Master-driven bits are sampled on mdc_rise.
  - The block updates its own drive on mdc_fall, giving half an MDC period of setup.
  - All fields are MSB first; one bit counter is reused per field.
- IDLE:
  - Count consecutive 1s on mdc_rise, saturating at PREAMBLE_LEN; a 0 clears the count.
  - A 0 sampled with count == PREAMBLE_LEN → ST2.
- ST2: sample 1 → OP; sample 0 → frame_err pulse, IDLE, count 0.
- OP (2 bits):
  - 01 = write, 10 = read.
  - 00/11 → frame_err pulse, IDLE.
- PHYAD (5 bits) then REGAD (5 bits).
  - On the 5th REGAD bit: if PHYAD != PHY_ADDR → SKIP; otherwise latch the read word.
  - Read word = status_in if REGAD == STATUS_REG, else regfile[REGAD].
- SKIP:
  - Count 18 mdc_rise (TA + DATA) without driving, then → IDLE.
  - busy stays high through SKIP.
- Write:
  - TA: 2 bits sampled and not checked.
  - DATA: 16 bits shifted in.
  - On the 16th mdc_rise (same sys_clk): regfile[REGAD] <= data, except STATUS_REG is read-only and not stored.
  - wr_valid pulses in all cases; wr_addr and wr_data update.
  - → IDLE.
- Read:
  - TA bit 1: stay Z.
  - On the mdc_fall after TA bit 1's mdc_rise, drive 0.
  - On each following mdc_fall, drive D15..D0.
  - On the mdc_fall after D0's mdc_rise: release to Z, pulse rd_done, → IDLE.
- busy: set on entering OP, cleared on entering IDLE.
- Preamble: the count restarts at 0 after every frame; suppressed-preamble operation is not supported.
- Abort on MDC idle: if no mdc edge for 1024 sys_clk while not IDLE → release mdio, IDLE, no pulses.
- Async reset mid-frame: mdio released immediately (combinational from reset); no partial write is committed.
- Back-to-back frames: the next preamble may start on the mdc_rise immediately after the previous frame's last bit.

Test Plan:
- 32x1 preamble, write PHY 0 REG 0 data 0x0100; then read REG 0 → wr_valid with wr_addr 0, wr_data 0x0100; the read drives TA 0 then 0x0100; rd_done pulses.
- status_in=0x796D, read REG 1 → 0x796D on mdio; writing 0xFFFF to REG 1 pulses wr_valid but a re-read still returns status_in.
- Write frame to PHYAD 3 → no wr_valid, mdio stays Z for the whole frame; a following frame to PHY 0 is decoded normally.
- 31-bit preamble then ST → ignored (busy stays 0); OP=11 after a valid preamble → frame_err pulse, busy 0.
- Assert sys_rst_n=0 at read data bit D7 → mdio Z in the same cycle, outputs 0; the next full read frame succeeds.
- Stop MDC mid-write for 1024 sys_clk → FSM returns to IDLE, regfile unchanged, no wr_valid.
